citadel_loader: RTL and testbench

Serial bootstrap master for the citadel SoC. Consumes command bytes from the host-side byte link, and for each command issues single-byte write or read transactions as an initiator on the picorv32-style native memory bus (mem_valid/mem_ready). Read data and status bytes return on the byte link. Holds the CPU core stopped until a Go command arrives.

---
 rtl/citadel_loader_pkg.sv | 29 ++
 rtl/citadel_loader_if.sv | 28 ++
 rtl/citadel_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_citadel_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/citadel_loader_pkg.sv
// Shared constants and state encoding for the citadel serial bootstrap loader.
// Opcodes and response bytes are the host protocol's wire values.
package citadel_loader_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_GO    = 8'h47;

   localparam logic [7:0] RSP_OK   = 8'h2E;
   localparam logic [7:0] RSP_BAD  = 8'h3F;
   localparam logic [7:0] RSP_TMO  = 8'h21;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WDATA,
      S_WBUS,
      S_RBUS,
      S_RSEND,
      S_RESP,
      S_ERR
   } state_e;

   // One-hot byte-lane strobe for the low two address bits.
   function automatic logic [3:0] laneStrobe(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/citadel_loader_if.sv
// Host byte link plus native memory bus of the citadel loader.
// The master modport is the loader's view; slave is the host/responder side.
interface citadel_loader_if;

   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_busy;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      input  rx_data, rx_ready, tx_busy, mem_ready, mem_rdata,
      output rx_ack, tx_data, tx_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output rx_data, rx_ready, tx_busy, mem_ready, mem_rdata,
      input  rx_ack, tx_data, tx_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/citadel_loader.sv
// Serial bootstrap master: parses host command frames and turns each data byte
// into a single-byte bus write or read, answering on the byte link.
module citadel_loader
   import citadel_loader_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   citadel_loader_if.master bus,
   output logic             core_run,
   output logic             busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e      state_q, state_d;
   logic        isWrite_q, isWrite_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] cur_q, cur_d;
   logic [15:0] rem_q, rem_d;
   logic [7:0]  rbyte_q, rbyte_d;
   logic [7:0]  resp_q, resp_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic        rx_ack_q, rx_ack_d;
   logic        tx_ready_q, tx_ready_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        core_run_q, core_run_d;

   logic        take;
   logic        canSend;
   logic        tmoHit;

   // rx_ready is ignored while the previous ack is still showing, and a tx
   // pulse always leaves one quiet cycle behind it.
   assign take    = bus.rx_ready && !rx_ack_q;
   assign canSend = !bus.tx_busy && !tx_ready_q;
   assign tmoHit  = (tmo_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         isWrite_q   <= 1'b0;
         cnt_q       <= 3'd0;
         cur_q       <= 32'd0;
         rem_q       <= 16'd0;
         rbyte_q     <= 8'd0;
         resp_q      <= 8'd0;
         tmo_q       <= '0;
         rx_ack_q    <= 1'b0;
         tx_ready_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_wstrb_q <= 4'd0;
         core_run_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         isWrite_q   <= isWrite_d;
         cnt_q       <= cnt_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         rbyte_q     <= rbyte_d;
         resp_q      <= resp_d;
         tmo_q       <= tmo_d;
         rx_ack_q    <= rx_ack_d;
         tx_ready_q  <= tx_ready_d;
         tx_data_q   <= tx_data_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         core_run_q  <= core_run_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      isWrite_d   = isWrite_q;
      cnt_d       = cnt_q;
      cur_d       = cur_q;
      rem_d       = rem_q;
      rbyte_d     = rbyte_q;
      resp_d      = resp_q;
      tmo_d       = tmo_q;
      rx_ack_d    = 1'b0;
      tx_ready_d  = 1'b0;
      tx_data_d   = tx_data_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      core_run_d  = core_run_q;

      case (state_q)
         S_IDLE: begin
            if (take) begin
               rx_ack_d = 1'b1;
               case (bus.rx_data)
                  OP_WRITE, OP_READ: begin
                     isWrite_d = (bus.rx_data == OP_WRITE);
                     cnt_d     = 3'd0;
                     state_d   = S_HDR;
                  end
                  OP_GO: begin
                     core_run_d = 1'b1;
                     resp_d     = RSP_OK;
                     state_d    = S_RESP;
                  end
                  default: begin
                     resp_d  = RSP_BAD;
                     state_d = S_RESP;
                  end
               endcase
            end
         end

         // Header bytes 0-3 land in the address, 4-5 in the remaining count.
         S_HDR: begin
            if (take) begin
               rx_ack_d = 1'b1;
               cnt_d    = cnt_q + 3'd1;
               if (cnt_q < 3'd4) begin
                  cur_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
               end else begin
                  rem_d[{cnt_q[0], 3'b000} +: 8] = bus.rx_data;
               end
               if (cnt_q == 3'd5) begin
                  if (rem_d == 16'd0) begin
                     resp_d  = RSP_OK;
                     state_d = S_RESP;
                  end else begin
                     state_d = isWrite_q ? S_WDATA : S_RBUS;
                  end
               end
            end
         end

         S_WDATA: begin
            if (take) begin
               rx_ack_d    = 1'b1;
               mem_addr_d  = {cur_q[31:2], 2'b00};
               mem_wdata_d = {4{bus.rx_data}};
               mem_wstrb_d = laneStrobe(cur_q[1:0]);
               state_d     = S_WBUS;
            end
         end

         S_WBUS: begin
            if (!mem_valid_q) begin
               mem_valid_d = 1'b1;
               tmo_d       = '0;
            end else if (bus.mem_ready) begin
               mem_valid_d = 1'b0;
               cur_d       = cur_q + 32'd1;
               rem_d       = rem_q - 16'd1;
               resp_d      = RSP_OK;
               state_d     = (rem_q == 16'd1) ? S_RESP : S_WDATA;
            end else if (tmoHit) begin
               mem_valid_d = 1'b0;
               state_d     = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         // The request fields are loaded together with mem_valid so they stay
         // frozen for the whole transaction.
         S_RBUS: begin
            if (!mem_valid_q) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = {cur_q[31:2], 2'b00};
               mem_wstrb_d = 4'd0;
               tmo_d       = '0;
            end else if (bus.mem_ready) begin
               mem_valid_d = 1'b0;
               rbyte_d     = bus.mem_rdata[{cur_q[1:0], 3'b000} +: 8];
               cur_d       = cur_q + 32'd1;
               rem_d       = rem_q - 16'd1;
               state_d     = S_RSEND;
            end else if (tmoHit) begin
               mem_valid_d = 1'b0;
               state_d     = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_RSEND: begin
            if (canSend) begin
               tx_ready_d = 1'b1;
               tx_data_d  = rbyte_q;
               if (rem_q == 16'd0) begin
                  resp_d  = RSP_OK;
                  state_d = S_RESP;
               end else begin
                  state_d = S_RBUS;
               end
            end
         end

         S_RESP: begin
            if (canSend) begin
               tx_ready_d = 1'b1;
               tx_data_d  = resp_q;
               state_d    = S_IDLE;
            end
         end

         S_ERR: begin
            if (canSend) begin
               tx_ready_d = 1'b1;
               tx_data_d  = RSP_TMO;
               state_d    = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rx_ack    = rx_ack_q;
   assign bus.tx_ready  = tx_ready_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign core_run      = core_run_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_citadel_loader.sv
// Directed bench for citadel_loader: command frames from a vector table, a
// modelled memory responder, and hand sequences for stalls, timeout and reset.
module tb_citadel_loader;

   localparam int TMO = 1024;

   logic clk;
   logic rst;
   logic coreRun;
   logic busy;

   citadel_loader_if bus();

   citadel_loader #(.TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .core_run (coreRun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } busTxn_t;

   typedef struct {
      string             name;
      int                nIn;
      logic [0:11][7:0]  inB;
      int                nTx;
      logic [0:3][7:0]   txB;
      int                nBus;
      logic [0:2][31:0]  bAddr;
      logic [0:2][3:0]   bStrb;
      logic [0:2][31:0]  bData;
      bit                coreRun;
   } vec_t;

   int checks = 0;
   int errors = 0;

   busTxn_t     busLog[$];
   logic [7:0]  txQ[$];
   logic [31:0] memory [logic [31:0]];

   bit   respOn  = 1'b1;
   int   respLat = 0;
   int   waitCnt = 0;

   int   cyc = 0;
   int   ackCyc = -10;
   int   curDur = 0;
   int   lastDur = 0;
   int   stabViol = 0;
   int   dropViol = 0;
   int   latViol = 0;
   int   txViol = 0;
   logic prevValid = 1'b0;
   logic prevTxReady = 1'b0;
   logic [31:0] prevAddr = 32'd0;
   logic [31:0] prevWdata = 32'd0;
   logic [3:0]  prevStrb = 4'd0;

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Observes the link and bus shortly after every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (bus.rx_ack) ackCyc = cyc;
         if (bus.tx_ready) begin
            txQ.push_back(bus.tx_data);
            if (bus.tx_busy || prevTxReady) txViol++;
         end
         prevTxReady = bus.tx_ready;
         if (prevValid && bus.mem_ready) begin
            if (bus.mem_valid) dropViol++;
         end else if (prevValid && bus.mem_valid) begin
            if (bus.mem_addr !== prevAddr || bus.mem_wdata !== prevWdata || bus.mem_wstrb !== prevStrb)
               stabViol++;
         end else if (!prevValid && bus.mem_valid) begin
            busLog.push_back('{bus.mem_addr, bus.mem_wstrb, bus.mem_wdata});
            if (bus.mem_wstrb != 4'd0 && cyc != ackCyc + 1) latViol++;
            curDur = 0;
         end
         if (bus.mem_valid) curDur++;
         else if (prevValid) lastDur = curDur;
         prevValid = bus.mem_valid;
         prevAddr  = bus.mem_addr;
         prevWdata = bus.mem_wdata;
         prevStrb  = bus.mem_wstrb;
      end
   end

   // Memory responder with programmable latency; can be silenced for timeouts.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         if (bus.mem_valid && !rst) begin
            if (respOn && waitCnt >= respLat) begin
               logic [31:0] w;
               w = memory.exists(bus.mem_addr) ? memory[bus.mem_addr] : 32'd0;
               bus.mem_rdata = w;
               for (int k = 0; k < 4; k++)
                  if (bus.mem_wstrb[k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
               memory[bus.mem_addr] = w;
               bus.mem_ready = 1'b1;
            end else begin
               waitCnt++;
            end
         end else begin
            waitCnt = 0;
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rx_ack && n < 3000);
      bus.rx_ready = 1'b0;
      if (!bus.rx_ack) checkOutput("rxAckTimeout", 96'(bus.rx_ack), 96'd1);
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput({name, "_idleTimeout"}, 96'(busy), 96'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkTx(input string name, input logic [0:3][7:0] exp, input int n);
      checkOutput({name, "_txCount"}, 96'(txQ.size()), 96'(n));
      for (int j = 0; j < n; j++)
         checkOutput($sformatf("%s_tx%0d", name, j),
                     (j < txQ.size()) ? 96'(txQ[j]) : 96'hDEAD, 96'(exp[j]));
   endtask

   initial begin
      vec_t    vecs[8];
      busTxn_t t;
      logic    seen;

      vecs[0] = '{"rd102", 7, {8'h52,8'h02,8'h01,8'h00,8'h00,8'h02,8'h00,{5{8'h00}}},
                  3, {8'h33,8'h44,8'h2E,8'h00},
                  2, {32'h100,32'h100,32'h0}, {4'h0,4'h0,4'h0}, {3{32'h0}}, 1'b0};
      vecs[1] = '{"rd103", 7, {8'h52,8'h03,8'h01,8'h00,8'h00,8'h02,8'h00,{5{8'h00}}},
                  3, {8'h44,8'h55,8'h2E,8'h00},
                  2, {32'h100,32'h104,32'h0}, {4'h0,4'h0,4'h0}, {3{32'h0}}, 1'b0};
      vecs[2] = '{"wr100", 10, {8'h57,8'h00,8'h01,8'h00,8'h00,8'h03,8'h00,8'hAA,8'hBB,8'hCC,{2{8'h00}}},
                  1, {8'h2E,8'h00,8'h00,8'h00},
                  3, {32'h100,32'h100,32'h100}, {4'h1,4'h2,4'h4},
                  {32'hAAAAAAAA,32'hBBBBBBBB,32'hCCCCCCCC}, 1'b0};
      vecs[3] = '{"rdBack", 7, {8'h52,8'h00,8'h01,8'h00,8'h00,8'h03,8'h00,{5{8'h00}}},
                  4, {8'hAA,8'hBB,8'hCC,8'h2E},
                  3, {32'h100,32'h100,32'h100}, {4'h0,4'h0,4'h0}, {3{32'h0}}, 1'b0};
      vecs[4] = '{"wrWrap", 9, {8'h57,8'hFF,8'hFF,8'hFF,8'hFF,8'h02,8'h00,8'h11,8'h22,{3{8'h00}}},
                  1, {8'h2E,8'h00,8'h00,8'h00},
                  2, {32'hFFFFFFFC,32'h00000000,32'h0}, {4'h8,4'h1,4'h0},
                  {32'h11111111,32'h22222222,32'h0}, 1'b0};
      vecs[5] = '{"wrLen0", 7, {8'h57,8'h00,8'h02,8'h00,8'h00,8'h00,8'h00,{5{8'h00}}},
                  1, {8'h2E,8'h00,8'h00,8'h00},
                  0, {3{32'h0}}, {3{4'h0}}, {3{32'h0}}, 1'b0};
      vecs[6] = '{"badOp", 1, {8'h00,{11{8'h00}}},
                  1, {8'h3F,8'h00,8'h00,8'h00},
                  0, {3{32'h0}}, {3{4'h0}}, {3{32'h0}}, 1'b0};
      vecs[7] = '{"go", 1, {8'h47,{11{8'h00}}},
                  1, {8'h2E,8'h00,8'h00,8'h00},
                  0, {3{32'h0}}, {3{4'h0}}, {3{32'h0}}, 1'b1};

      memory[32'h100] = 32'h44332211;
      memory[32'h104] = 32'h88776655;

      rst          = 1'b0;
      bus.rx_data  = 8'd0;
      bus.rx_ready = 1'b0;
      bus.tx_busy  = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("resetOutputs",
                  96'({bus.rx_ack, bus.tx_ready, bus.mem_valid, coreRun, busy,
                       bus.tx_data, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}), 96'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idleAfterReset", 96'(busy), 96'd0);

      for (int i = 0; i < 8; i++) begin
         txQ.delete();
         busLog.delete();
         respLat = i % 3;
         for (int j = 0; j < vecs[i].nIn; j++) applyStimulus(vecs[i].inB[j]);
         waitIdle(vecs[i].name);
         checkTx(vecs[i].name, vecs[i].txB, vecs[i].nTx);
         checkOutput({vecs[i].name, "_busCount"}, 96'(busLog.size()), 96'(vecs[i].nBus));
         for (int j = 0; j < vecs[i].nBus; j++) begin
            t = (j < busLog.size()) ? busLog[j] : '{32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
            checkOutput($sformatf("%s_addr%0d", vecs[i].name, j), 96'(t.addr), 96'(vecs[i].bAddr[j]));
            checkOutput($sformatf("%s_strb%0d", vecs[i].name, j), 96'(t.strb), 96'(vecs[i].bStrb[j]));
            if (vecs[i].bStrb[j] != 4'h0)
               checkOutput($sformatf("%s_wdata%0d", vecs[i].name, j), 96'(t.data), 96'(vecs[i].bData[j]));
         end
         checkOutput({vecs[i].name, "_coreRun"}, 96'(coreRun), 96'(vecs[i].coreRun));
      end

      // Host link stalled while a read produces data: nothing may leak out.
      respLat = 0;
      txQ.delete();
      @(negedge clk);
      bus.tx_busy = 1'b1;
      applyStimulus(8'h52); applyStimulus(8'h01); applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h00);
      repeat (50) @(negedge clk);
      checkOutput("txBusy_noPulse", 96'(txQ.size()), 96'd0);
      bus.tx_busy = 1'b0;
      waitIdle("txBusy");
      checkTx("txBusy", {8'hBB, 8'hCC, 8'h2E, 8'h00}, 3);

      // Silent responder: abort after the timeout, then leftover data is a new opcode.
      respOn = 1'b0;
      txQ.delete();
      busLog.delete();
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h5A);
      waitIdle("timeout");
      checkOutput("timeout_validCycles", 96'(lastDur), 96'(TMO));
      checkOutput("timeout_busCount", 96'(busLog.size()), 96'd1);
      checkOutput("timeout_validLow", 96'(bus.mem_valid), 96'd0);
      checkOutput("timeout_busy", 96'(busy), 96'd0);
      checkTx("timeout", {8'h21, 8'h00, 8'h00, 8'h00}, 1);
      respOn = 1'b1;
      txQ.delete();
      applyStimulus(8'h13);
      waitIdle("resync");
      checkTx("resync", {8'h3F, 8'h00, 8'h00, 8'h00}, 1);

      // Reset asserted while a read is stalled on the bus.
      respOn = 1'b0;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = bus.mem_valid;
      end
      checkOutput("rstMid_validBefore", 96'(bus.mem_valid), 96'd1);
      checkOutput("rstMid_coreRunBefore", 96'(coreRun), 96'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rstMid_outputs",
                  96'({bus.rx_ack, bus.tx_ready, bus.mem_valid, coreRun, busy,
                       bus.tx_data, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}), 96'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      respOn = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("busStable", 96'(stabViol), 96'd0);
      checkOutput("validDropAfterReady", 96'(dropViol), 96'd0);
      checkOutput("writeLatency", 96'(latViol), 96'd0);
      checkOutput("txPulseRules", 96'(txViol), 96'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
